// File: rtl/fifo_top_if.sv
// Shared FIFO sizing package and the FIFO port bundle.
// The tstr modport is the mirror image of fifo, for whatever drives the FIFO.
package afifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
endpackage

interface fifo_if;
  import afifo_pkg::*;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport fifo (
    input  push,
    input  pop,
    input  data_in,
    output data_out,
    output rd_valid,
    output full,
    output empty,
    output count,
    output overflow,
    output underflow
  );

  modport tstr (
    output push,
    output pop,
    output data_in,
    input  data_out,
    input  rd_valid,
    input  full,
    input  empty,
    input  count,
    input  overflow,
    input  underflow
  );
endinterface

// File: rtl/fifo_top.sv
// Single-clock FIFO with registered read data and one-cycle error pulses.
// Pointers carry an extra wrap bit so full and empty need no separate counter.
module fifo_top
  import afifo_pkg::*;
(
  input logic  wr_clk,
  input logic  wr_rst,
  input logic  rd_clk,
  input logic  rd_rst,
  fifo_if.fifo itf
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic                  rst;
  logic                  unused_rd_clk;

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rv_q, rv_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  full, empty;
  logic                  push_ok, pop_ok;

  // rd_clk shares its source with wr_clk; it exists for port compatibility.
  assign unused_rd_clk = rd_clk;
  assign rst           = wr_rst | rd_rst;

  assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_addr == rd_addr) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign push_ok = itf.push & ~full;
  assign pop_ok  = itf.pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    rv_d     = 1'b0;
    ovf_d    = itf.push & full;
    udf_d    = itf.pop & empty;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = mem_q[rd_addr];
      rv_d     = 1'b1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      rv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      rv_q     <= rv_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never cleared; the pointer reset alone discards old words.
  always_ff @(posedge wr_clk) begin
    if (push_ok && !rst) begin
      mem_q[wr_addr] <= itf.data_in;
    end
  end

  assign itf.data_out  = dout_q;
  assign itf.rd_valid  = rv_q;
  assign itf.full      = full;
  assign itf.empty     = empty;
  assign itf.count     = wr_ptr_q - rd_ptr_q;
  assign itf.overflow  = ovf_q;
  assign itf.underflow = udf_q;

endmodule

// File: tb/tb_fifo_top.sv
// Directed bench for fifo_top: a vector table plus hand-written
// sequences for wrap-around, simultaneous push/pop and reset priority.
module tb_fifo_top;
  import afifo_pkg::*;

  typedef struct {
    logic       wr;
    logic       rr;
    logic       ps;
    logic       pp;
    logic [7:0] din;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic [7:0] dout;
    logic       rv;
    logic       ovf;
    logic       udf;
  } vec_t;

  logic clk = 1'b0;
  logic wr_rst = 1'b0;
  logic rd_rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fifo_if itf ();

  fifo_top dut (
    .wr_clk (clk),
    .wr_rst (wr_rst),
    .rd_clk (clk),
    .rd_rst (rd_rst),
    .itf    (itf)
  );

  function automatic vec_t mk(
    logic wr, logic rr, logic ps, logic pp, logic [7:0] din,
    logic [3:0] cnt, logic full, logic empty, logic [7:0] dout,
    logic rv, logic ovf, logic udf);
    vec_t v;
    v.wr = wr; v.rr = rr; v.ps = ps; v.pp = pp; v.din = din;
    v.cnt = cnt; v.full = full; v.empty = empty; v.dout = dout;
    v.rv = rv; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic wr, input logic rr, input logic ps,
                      input logic pp, input logic [7:0] d);
    @(negedge clk);
    wr_rst       = wr;
    rd_rst       = rr;
    itf.push     = ps;
    itf.pop      = pp;
    itf.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string t, input logic [3:0] cnt,
                           input logic full, input logic empty,
                           input logic [7:0] dout, input logic rv,
                           input logic ovf, input logic udf);
    chk({t, ".count"}, 32'(itf.count), 32'(cnt));
    chk({t, ".full"}, 32'(itf.full), 32'(full));
    chk({t, ".empty"}, 32'(itf.empty), 32'(empty));
    chk({t, ".data_out"}, 32'(itf.data_out), 32'(dout));
    chk({t, ".rd_valid"}, 32'(itf.rd_valid), 32'(rv));
    chk({t, ".overflow"}, 32'(itf.overflow), 32'(ovf));
    chk({t, ".underflow"}, 32'(itf.underflow), 32'(udf));
  endtask

  initial begin
    int n_ovf;
    int n_udf;
    int k;

    itf.push    = 1'b0;
    itf.pop     = 1'b0;
    itf.data_in = '0;

    // reset through each input, then both
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0, 0, 1, 0, 8'(i), 4'(i), (i == 8), 0,
                       8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h09, 8, 1, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8, 1, 0, 8'h00, 0, 0, 0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0, 0, 0, 1, 8'h00, 4'(8 - i), 0, (i == 8),
                       8'(i), 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 1, 8'h08, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 1, 8'h08, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].rr, tbl[i].ps, tbl[i].pp, tbl[i].din);
      check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].full,
                tbl[i].empty, tbl[i].dout, tbl[i].rv, tbl[i].ovf,
                tbl[i].udf);
    end

    // five rounds of 15 pushes / 20 pops: pointers wrap repeatedly
    for (int r = 0; r < 5; r++) begin
      n_ovf = 0;
      n_udf = 0;
      k = 0;
      for (int v = 1; v <= 15; v++) begin
        step(0, 0, 1, 0, 8'(v));
        if (itf.overflow === 1'b1) n_ovf++;
      end
      for (int j = 0; j < 20; j++) begin
        step(0, 0, 0, 1, 8'h00);
        if (itf.underflow === 1'b1) n_udf++;
        if (itf.rd_valid === 1'b1) begin
          chk($sformatf("round%0d.data%0d", r, k),
              32'(itf.data_out), 32'(k + 1));
          k++;
        end
      end
      chk($sformatf("round%0d.ovf_pulses", r), 32'(n_ovf), 32'd7);
      chk($sformatf("round%0d.udf_pulses", r), 32'(n_udf), 32'd12);
      chk($sformatf("round%0d.reads", r), 32'(k), 32'd8);
      chk($sformatf("round%0d.empty", r), 32'(itf.empty), 32'd1);
    end

    // simultaneous push and pop at mid, full and empty occupancy
    step(1, 1, 0, 0, 8'h00);
    check_all("sim.rst", 0, 0, 1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'(8'h10 + i));
    step(0, 0, 1, 1, 8'h14);
    check_all("sim.mid", 4, 0, 0, 8'h10, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'(8'h15 + i));
    chk("sim.full_before", 32'(itf.full), 32'd1);
    step(0, 0, 1, 1, 8'h99);
    check_all("sim.full", 7, 0, 0, 8'h11, 1, 1, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 1, 8'h00);
      chk($sformatf("sim.drain%0d", i), 32'(itf.data_out),
          32'(8'h12 + i));
    end
    chk("sim.drained_empty", 32'(itf.empty), 32'd1);
    step(0, 0, 1, 1, 8'h55);
    check_all("sim.empty", 1, 0, 0, 8'h18, 0, 0, 1);
    step(0, 0, 0, 1, 8'h00);
    check_all("sim.readback", 0, 0, 1, 8'h55, 1, 0, 0);

    // reset wins over a concurrent push and drops stored words
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'(8'h20 + i));
    chk("rstprio.count5", 32'(itf.count), 32'd5);
    step(1, 0, 1, 0, 8'h77);
    check_all("rstprio.rst", 0, 0, 1, 8'h00, 0, 0, 0);
    step(0, 0, 0, 1, 8'h00);
    check_all("rstprio.pop", 0, 0, 1, 8'h00, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
